// File: rtl/hangman_pkg.sv
// -----------------------------------------------------------------------------
// hangman_pkg
// Shared definitions for the blind-hangman datapath:
//   - letter/word geometry (LETTER_W, WORD_LEN, WORD_W) and their types
//   - letter codes LTR_A..LTR_Z (A=1 .. Z=26, 0 = no letter)
//   - guessed-mask operation codes GL_CLR / GL_OR / GL_ALL
//   - the word ROM contents (letter 0 sits in the least-significant slot)
//   - sanitize_letter(): maps invalid codes (0, 27..31) to 0
// No ports (package).
// -----------------------------------------------------------------------------
package hangman_pkg;

    localparam int LETTER_W = 5;
    localparam int WORD_LEN = 5;
    localparam int WORD_W   = LETTER_W * WORD_LEN;

    typedef logic [LETTER_W-1:0] letter_t;
    typedef logic [WORD_W-1:0]   word_t;
    typedef logic [WORD_LEN-1:0] mask_t;

    localparam letter_t LTR_NONE = 5'd0;
    localparam letter_t LTR_A = 5'd1;
    localparam letter_t LTR_B = 5'd2;
    localparam letter_t LTR_C = 5'd3;
    localparam letter_t LTR_D = 5'd4;
    localparam letter_t LTR_E = 5'd5;
    localparam letter_t LTR_F = 5'd6;
    localparam letter_t LTR_G = 5'd7;
    localparam letter_t LTR_H = 5'd8;
    localparam letter_t LTR_I = 5'd9;
    localparam letter_t LTR_J = 5'd10;
    localparam letter_t LTR_K = 5'd11;
    localparam letter_t LTR_L = 5'd12;
    localparam letter_t LTR_M = 5'd13;
    localparam letter_t LTR_N = 5'd14;
    localparam letter_t LTR_O = 5'd15;
    localparam letter_t LTR_P = 5'd16;
    localparam letter_t LTR_Q = 5'd17;
    localparam letter_t LTR_R = 5'd18;
    localparam letter_t LTR_S = 5'd19;
    localparam letter_t LTR_T = 5'd20;
    localparam letter_t LTR_U = 5'd21;
    localparam letter_t LTR_V = 5'd22;
    localparam letter_t LTR_W = 5'd23;
    localparam letter_t LTR_X = 5'd24;
    localparam letter_t LTR_Y = 5'd25;
    localparam letter_t LTR_Z = 5'd26;

    localparam logic [2:0] GL_CLR = 3'd0;
    localparam logic [2:0] GL_OR  = 3'd1;
    localparam logic [2:0] GL_ALL = 3'd2;

    // Words are packed {l4,l3,l2,l1,l0}: the first letter is in bits [4:0].
    localparam word_t WORD_HELLO = {LTR_O, LTR_L, LTR_L, LTR_E, LTR_H};
    localparam word_t WORD_CHIPS = {LTR_S, LTR_P, LTR_I, LTR_H, LTR_C};
    localparam word_t WORD_GATES = {LTR_S, LTR_E, LTR_T, LTR_A, LTR_G};
    localparam word_t WORD_LOGIC = {LTR_C, LTR_I, LTR_G, LTR_O, LTR_L};
    localparam word_t WORD_CLOCK = {LTR_K, LTR_C, LTR_O, LTR_L, LTR_C};
    localparam word_t WORD_ADDER = {LTR_R, LTR_E, LTR_D, LTR_D, LTR_A};
    localparam word_t WORD_RESET = {LTR_T, LTR_E, LTR_S, LTR_E, LTR_R};
    localparam word_t WORD_SHIFT = {LTR_T, LTR_F, LTR_I, LTR_H, LTR_S};

    // Only A..Z are real letters; anything else is stored as "no letter".
    function automatic letter_t sanitize_letter(input logic [LETTER_W-1:0] c);
        return ((c >= LTR_A) && (c <= LTR_Z)) ? c : LTR_NONE;
    endfunction

endpackage

// File: rtl/hangman_datapath_if.sv
// -----------------------------------------------------------------------------
// hangman_datapath_if
// Bundles the controller <-> datapath signals.
//   master modport (controller side): drives char_in and all s_*/en_* strobes,
//                                     reads status and game state.
//   slave  modport (datapath side):   the reverse.
// Signals:
//   char_in[4:0], s_tries, en_tries, s_guessed_letters[2:0], en_guessed_letters,
//   en_word_index, en_input_char, s_win, en_win, s_lose, en_lose      (to datapath)
//   input_char_eq_word[4:0], guessed_letters_is_done, tries_is_zero, tries[2:0],
//   guessed_letters[4:0], win, lose, word_index[IDX_W-1:0]            (from datapath)
// -----------------------------------------------------------------------------
interface hangman_datapath_if #(
    parameter int IDX_W = 3
);
    logic [4:0]       char_in;
    logic             s_tries;
    logic             en_tries;
    logic [2:0]       s_guessed_letters;
    logic             en_guessed_letters;
    logic             en_word_index;
    logic             en_input_char;
    logic             s_win;
    logic             en_win;
    logic             s_lose;
    logic             en_lose;

    logic [4:0]       input_char_eq_word;
    logic             guessed_letters_is_done;
    logic             tries_is_zero;
    logic [2:0]       tries;
    logic [4:0]       guessed_letters;
    logic             win;
    logic             lose;
    logic [IDX_W-1:0] word_index;

    modport master (
        output char_in, s_tries, en_tries, s_guessed_letters, en_guessed_letters,
               en_word_index, en_input_char, s_win, en_win, s_lose, en_lose,
        input  input_char_eq_word, guessed_letters_is_done, tries_is_zero, tries,
               guessed_letters, win, lose, word_index
    );

    modport slave (
        input  char_in, s_tries, en_tries, s_guessed_letters, en_guessed_letters,
               en_word_index, en_input_char, s_win, en_win, s_lose, en_lose,
        output input_char_eq_word, guessed_letters_is_done, tries_is_zero, tries,
               guessed_letters, win, lose, word_index
    );
endinterface

// File: rtl/hangman_word_rom.sv
// -----------------------------------------------------------------------------
// hangman_word_rom
// Combinational secret-word table.
// Ports:
//   i_index [IDX_W-1:0]  word number
//   o_word  [24:0]       packed word, first letter in bits [4:0]
// The table holds eight distinct words; larger indices reuse them modulo 8.
// -----------------------------------------------------------------------------
module hangman_word_rom
    import hangman_pkg::*;
#(
    parameter int IDX_W = 3
) (
    input  logic [IDX_W-1:0] i_index,
    output word_t            o_word
);

    logic [2:0] w_sel;

    assign w_sel = 3'(i_index);

    always_comb begin
        o_word = WORD_HELLO;
        case (w_sel)
            3'd0:    o_word = WORD_HELLO;
            3'd1:    o_word = WORD_CHIPS;
            3'd2:    o_word = WORD_GATES;
            3'd3:    o_word = WORD_LOGIC;
            3'd4:    o_word = WORD_CLOCK;
            3'd5:    o_word = WORD_ADDER;
            3'd6:    o_word = WORD_RESET;
            default: o_word = WORD_SHIFT;
        endcase
    end

endmodule

// File: rtl/hangman_datapath.sv
// -----------------------------------------------------------------------------
// hangman_datapath
// Datapath under the blind-hangman controller: secret word, latched guess,
// revealed-letter mask, tries counter and win/lose flags.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   dp     hangman_datapath_if.slave (controller strobes in, status out)
// Parameters:
//   MAX_TRIES  value loaded into tries at game start (1..7)
//   NUM_WORDS  word ROM depth (power of two, 2..256)
//   IDX_W      word index width
// Build option:
//   HANGMAN_LFSR_EN  defined   -> word index taken from an 8-bit Fibonacci LFSR
//                                 (x^8+x^6+x^5+x^4+1, seed 8'h01)
//                    undefined -> word index is a free-running up-counter
// -----------------------------------------------------------------------------
module hangman_datapath
    import hangman_pkg::*;
#(
    parameter int MAX_TRIES = 7,
    parameter int NUM_WORDS = 8,
    parameter int IDX_W     = $clog2(NUM_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    hangman_datapath_if.slave dp
);

    logic [IDX_W-1:0] w_gen_idx;
    word_t            w_rom_word;

    word_t            r_word;
    logic [IDX_W-1:0] r_word_index;
    letter_t          r_char;
    mask_t            r_guessed;
    logic [2:0]       r_tries;
    logic             r_win;
    logic             r_lose;

    mask_t            w_eq;
    mask_t            w_guessed_next;
    logic [2:0]       w_tries_next;

    // Free-running index generator; the cycle on which the controller starts
    // a game decides which word is picked.
`ifdef HANGMAN_LFSR_EN
    logic [7:0] r_lfsr;
    logic       w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 8'h01;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    assign w_gen_idx = r_lfsr[IDX_W-1:0];
`else
    logic [IDX_W-1:0] r_gen_cnt;

    // NUM_WORDS is a power of two, so natural overflow gives the wrap to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gen_cnt <= '0;
        end else begin
            r_gen_cnt <= r_gen_cnt + 1'b1;
        end
    end

    assign w_gen_idx = r_gen_cnt;
`endif

    hangman_word_rom #(
        .IDX_W (IDX_W)
    ) u_rom (
        .i_index (w_gen_idx),
        .o_word  (w_rom_word)
    );

    // Letter comparators: a blank guess (0) never matches, repeated letters
    // light several bits.
    always_comb begin
        w_eq = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            w_eq[i] = (r_char != LTR_NONE) &&
                      (r_char == r_word[i*LETTER_W +: LETTER_W]);
        end
    end

    // OR-in uses the current (pre-edge) compare, so a guess latched on the
    // same edge or a word swapped on the same edge does not affect it.
    always_comb begin
        w_guessed_next = r_guessed;
        case (dp.s_guessed_letters)
            GL_CLR:  w_guessed_next = '0;
            GL_OR:   w_guessed_next = r_guessed | w_eq;
            GL_ALL:  w_guessed_next = '1;
            default: w_guessed_next = r_guessed;
        endcase
    end

    // Decrement saturates at zero rather than wrapping to 7.
    always_comb begin
        w_tries_next = r_tries;
        if (dp.s_tries) begin
            w_tries_next = 3'(MAX_TRIES);
        end else if (r_tries != 3'd0) begin
            w_tries_next = r_tries - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word       <= WORD_HELLO;
            r_word_index <= '0;
            r_char       <= LTR_NONE;
            r_guessed    <= '0;
            r_tries      <= 3'd0;
            r_win        <= 1'b0;
            r_lose       <= 1'b0;
        end else begin
            if (dp.en_word_index) begin
                r_word       <= w_rom_word;
                r_word_index <= w_gen_idx;
            end
            if (dp.en_input_char) begin
                r_char <= sanitize_letter(dp.char_in);
            end
            if (dp.en_guessed_letters) begin
                r_guessed <= w_guessed_next;
            end
            if (dp.en_tries) begin
                r_tries <= w_tries_next;
            end
            if (dp.en_win) begin
                r_win <= dp.s_win;
            end
            if (dp.en_lose) begin
                r_lose <= dp.s_lose;
            end
        end
    end

    assign dp.input_char_eq_word      = w_eq;
    assign dp.guessed_letters_is_done = &r_guessed;
    assign dp.tries_is_zero           = (r_tries == 3'd0);
    assign dp.tries                   = r_tries;
    assign dp.guessed_letters         = r_guessed;
    assign dp.win                     = r_win;
    assign dp.lose                    = r_lose;
    assign dp.word_index              = r_word_index;

endmodule
